iiitb_fifo_uart_tx: RTL and testbench
=====================================

# iiitb_fifo_uart_tx

Serial transmitter that drains the 8-entry byte FIFO (`iiitb_fifo`) and sends each byte as an asynchronous UART frame: 8N1, LSB first. It sits directly downstream of the FIFO. It drives the FIFO's `rd_en` from the FIFO's `buf_empty` flag and captures the FIFO's registered `buf_out`. Frames are sent back-to-back while data is available and `tx_en` is high.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `DATA_W`, default 8: byte width; must match the FIFO data width.
- `clk`  in  1: sole clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset. Asserting it (0) resets immediately; deassertion is synchronous to `clk`.
- `tx_en`  in  1: permits starting a new frame.
- `buf_empty`  in  1: FIFO empty flag.
- `buf_out`  in  DATA_W: FIFO read data, valid the cycle after an `rd_en` cycle.
- `rd_en`  out  1: FIFO pop strobe, registered, one cycle wide.
- `tx`  out  1: serial line, registered, idle high.
- `busy`  out  1: high in every state except IDLE.
- `tx_done`  out  1: one-cycle pulse in the last cycle of the stop bit.
- `frames_sent`  out  16: count of completed frames, wraps 0xFFFF→0.

## Operation
- Reset values: `rd_en`=0, `tx`=1, `busy`=0, `tx_done`=0, `frames_sent`=0. State is IDLE and all counters are 0.
- FSM states: IDLE → FETCH → LOAD → START → DATA → [PARITY] → STOP → IDLE.
- IDLE: moves to FETCH when `tx_en`=1 and `buf_empty`=0 are sampled. Otherwise stays in IDLE.
- FETCH: lasts 1 cycle with `rd_en`=1. The FIFO pops on the closing edge.
- LOAD: lasts 1 cycle. The shift register captures `buf_out` on the closing edge.
- START: `tx`=0 for CLKS_PER_BIT cycles.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit index counts 0..7.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. `tx_done` pulses in the last cycle. `frames_sent` increments on the same edge.
- The baud counter runs 0..CLKS_PER_BIT-1 and emits `bit_tick` at the terminal count. It is cleared on every state entry.
- `rd_en` is never asserted unless `buf_empty` was 0 in the preceding cycle. `rd_en` is never asserted in two consecutive cycles. This guarantees the FIFO never underflows.
- `tx_en` dropping mid-frame has no effect on the current frame. It only blocks the next IDLE→FETCH transition.
- `buf_empty` is ignored outside IDLE.
- Reset asserted mid-frame: the in-flight byte is lost, `tx` goes to 1 immediately, and no `tx_done` pulse is generated.
- The FIFO's `fifo_counter` and `buf_full` are not consumed.

## Timing
- Cycle n: IDLE samples the start condition.
- Cycle n+1: `rd_en`=1.
- Cycle n+2: LOAD.
- Cycle n+3: `tx` falls for the start bit. Start latency is 3 cycles.
- Frame length is 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- Back-to-back: STOP always returns to IDLE. The IDLE-to-IDLE period per byte is 10·CLKS_PER_BIT+3 cycles, or 11·CLKS_PER_BIT+3 with parity.
- Simultaneous push into the FIFO during FETCH is legal. It is the FIFO's concern, not this block's.

## Configuration
- `IIITB_UART_PARITY_EN` defined: a PARITY state is inserted between DATA and STOP. It transmits the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
- Macro undefined: the PARITY state and its logic are absent, and the frame is 8N1.

## Structure
- Package `iiitb_fifo_pkg` holds:
  - `BUF_WIDTH`=3 and `DATA_W`=8;
  - the FSM state typedef;
  - the `TX_IDLE_LEVEL`=1 constant.
- One sub-module, `iiitb_baud_gen`, which is the CLKS_PER_BIT counter. Its ports are `clk`, `rst`, `clear` and `bit_tick`.
- The FSM, the shift register and `frames_sent` live in the top module.

## Test plan
All scenarios use CLKS_PER_BIT=4, with the block connected to `iiitb_fifo`.
- Single byte: push 0xA5 with `tx_en`=1.
  - `rd_en` is high for exactly one cycle.
  - `tx` sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1.
  - `tx_done` pulses once and `frames_sent`=1.
  - `buf_empty` returns to 1.
- Parity build: same stimulus. After the data bits and before the stop bit, the parity bit is 0 for 0xA5 and 1 for 0x01.
- Burst: push 8 bytes (1,2,10,20,30,40,50,60) to fill the FIFO.
  - Exactly 8 frames go out, in order, 43 cycles apart (47 with parity).
  - There are 8 `rd_en` pulses and `frames_sent`=8.
  - No `rd_en` pulse occurs while `buf_empty`=1.
- `tx_en` gating: push 2 bytes with `tx_en`=0.
  - `tx` stays 1, `rd_en` stays 0, and `busy` stays 0 for 100 cycles.
  - Raise `tx_en`: both frames are sent. Drop `tx_en` during the first frame's DATA state: the first frame completes and the second is not started.
- Reset mid-frame: assert `rst`=0 during DATA bit 3.
  - In the same cycle, `tx`=1, `busy`=0 and `frames_sent`=0.
  - After release with the FIFO re-primed with 0x3C, a clean frame for 0x3C is sent.
- Counter wrap: preload the bench-forced `frames_sent` to 0xFFFF and send one byte. `frames_sent` becomes 0x0000.

Source files
------------

// File: rtl/iiitb_fifo_pkg.sv
// Shared constants and FSM encoding for the FIFO-fed UART transmitter.
package iiitb_fifo_pkg;

    localparam int unsigned BUF_WIDTH = 3;
    localparam int unsigned DATA_W    = 8;

    localparam logic TX_IDLE_LEVEL = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_FETCH  = 3'd1;
    localparam state_t ST_LOAD   = 3'd2;
    localparam state_t ST_START  = 3'd3;
    localparam state_t ST_DATA   = 3'd4;
    localparam state_t ST_PARITY = 3'd5;
    localparam state_t ST_STOP   = 3'd6;

endpackage

// File: rtl/iiitb_fifo_uart_tx_baud.sv
// Bit-period counter: runs 0..CLKS_PER_BIT-1, flags the terminal count.
module iiitb_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic bit_tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    // Free-running within a state; restarts from 0 on clear or wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear || (cnt == TERM)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign bit_tick = (cnt == TERM);

endmodule

// File: rtl/iiitb_fifo_uart_tx.sv
// UART transmitter draining the iiitb_fifo byte FIFO (8N1, LSB first).
// Optional even parity bit between data and stop: define IIITB_UART_PARITY_EN.
module iiitb_fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_en,
    input  logic              buf_empty,
    input  logic [DATA_W-1:0] buf_out,
    output logic              rd_en,
    output logic              tx,
    output logic              busy,
    output logic              tx_done,
    output logic [15:0]       frames_sent
);

    import iiitb_fifo_pkg::*;

    localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [IDX_W-1:0]  bit_idx;
    logic              bit_tick;
    logic              clear;
    logic              tx_nxt;
`ifdef IIITB_UART_PARITY_EN
    logic              parity_q;
`endif

    iiitb_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bit_tick (bit_tick)
    );

    // Next-state and next line level; tx is registered from the next state
    // so the line changes on the same edge that enters each state.
    always_comb begin
        state_nxt = state;
        tx_nxt    = TX_IDLE_LEVEL;
        case (state)
            ST_IDLE:  if (tx_en && !buf_empty) state_nxt = ST_FETCH;
            ST_FETCH: state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_START;
            ST_START: if (bit_tick) state_nxt = ST_DATA;
            ST_DATA: begin
                if (bit_tick && (bit_idx == LAST_IDX)) begin
`ifdef IIITB_UART_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
                end
            end
`ifdef IIITB_UART_PARITY_EN
            ST_PARITY: if (bit_tick) state_nxt = ST_STOP;
`endif
            ST_STOP:  if (bit_tick) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            // Staying in DATA across a tick means the register shifts this edge.
            ST_DATA:   tx_nxt = ((state == ST_DATA) && bit_tick) ? shreg[1] : shreg[0];
`ifdef IIITB_UART_PARITY_EN
            ST_PARITY: tx_nxt = parity_q;
`endif
            default:   tx_nxt = TX_IDLE_LEVEL;
        endcase
    end

    // Baud counter restarts on every state entry.
    assign clear = (state_nxt != state);

    // Last cycle of the stop bit.
    assign tx_done = (state == ST_STOP) && bit_tick;

    // State register and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            rd_en <= 1'b0;
            tx    <= TX_IDLE_LEVEL;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_en <= (state_nxt == ST_FETCH);
            tx    <= tx_nxt;
            busy  <= (state_nxt != ST_IDLE);
        end
    end

    // Shift register loads FIFO data in LOAD, shifts right on each data-bit tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_idx <= '0;
        end else begin
            if (state == ST_LOAD) begin
                shreg <= buf_out;
            end else if ((state == ST_DATA) && bit_tick) begin
                shreg <= {1'b0, shreg[DATA_W-1:1]};
            end
            if (state_nxt != ST_DATA) begin
                bit_idx <= '0;
            end else if ((state == ST_DATA) && bit_tick) begin
                bit_idx <= bit_idx + IDX_W'(1);
            end
        end
    end

`ifdef IIITB_UART_PARITY_EN
    // Even parity of the byte, captured alongside the shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_q <= 1'b0;
        end else if (state == ST_LOAD) begin
            parity_q <= ^buf_out;
        end
    end
`endif

    // Completed-frame counter, advances on the closing edge of the stop bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frames_sent <= 16'd0;
        end else if ((state == ST_STOP) && bit_tick) begin
            frames_sent <= frames_sent + 16'd1;
        end
    end

endmodule

// File: tb/tb_iiitb_fifo_uart_tx.sv
// Bench for iiitb_fifo_uart_tx with a behavioural 8-entry FIFO in front.
`timescale 1ns/1ps
module tb_iiitb_fifo_uart_tx;

    import iiitb_fifo_pkg::*;

    localparam int unsigned CPB = 4;
`ifdef IIITB_UART_PARITY_EN
    localparam int unsigned NBITS = 11;
`else
    localparam int unsigned NBITS = 10;
`endif
    localparam int unsigned FRAME = NBITS * CPB;
    localparam int unsigned DEPTH = 1 << BUF_WIDTH;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tx_en = 1'b0;
    logic        buf_empty;
    logic [7:0]  buf_out;
    logic        rd_en;
    logic        tx;
    logic        busy;
    logic        tx_done;
    logic [15:0] frames_sent;

    always #5 clk = ~clk;

    iiitb_fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_en       (tx_en),
        .buf_empty   (buf_empty),
        .buf_out     (buf_out),
        .rd_en       (rd_en),
        .tx          (tx),
        .busy        (busy),
        .tx_done     (tx_done),
        .frames_sent (frames_sent)
    );

    // Behavioural FIFO: combinational empty flag, registered read data.
    logic                 wr_en = 1'b0;
    logic [7:0]           buf_in = 8'h00;
    logic [7:0]           mem [DEPTH];
    logic [BUF_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [BUF_WIDTH:0]   fcnt;
    logic                 wr_ok, rd_ok;

    assign buf_empty = (fcnt == 0);
    assign wr_ok = wr_en && (fcnt != (BUF_WIDTH+1)'(DEPTH));
    assign rd_ok = rd_en && (fcnt != 0);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fcnt    <= '0;
            buf_out <= 8'h00;
        end else begin
            if (wr_ok) begin
                mem[wr_ptr] <= buf_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                buf_out <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            case ({wr_ok, rd_ok})
                2'b10:   fcnt <= fcnt + 1'b1;
                2'b01:   fcnt <= fcnt - 1'b1;
                default: fcnt <= fcnt;
            endcase
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard state shared between stimulus and monitor.
    logic [7:0] exp_q[$];
    int   cyc = 0;
    int   rx_k = 0;
    bit   rx_active = 0;
    logic [7:0] rx_byte;
    int   rx_frames = 0;
    int   done_cnt = 0;
    int   rd_pulses = 0;
    int   last_rd_cyc = -100;
    int   prev_start = 0;
    bit   have_prev = 0;
    bit   check_gap = 0;
    bit   prev_rd = 0;
    bit   prev_empty = 1;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: rd_en protocol checks plus a UART receiver sampling mid-bit.
    always @(negedge clk) begin
        if (!rst) begin
            rx_active  = 0;
            prev_rd    = 0;
            prev_empty = 1;
        end else begin
            if (rd_en) begin
                check("rd_en_after_nonempty", 32'(prev_empty), 32'd0);
                check("rd_en_single_cycle", 32'(prev_rd), 32'd0);
                rd_pulses++;
                last_rd_cyc = cyc;
            end
            prev_rd    = rd_en;
            prev_empty = buf_empty;

            if (rx_active) begin
                rx_k++;
            end else if (tx === 1'b0) begin
                rx_active = 1;
                rx_k      = 0;
                check("start_latency", 32'(cyc - last_rd_cyc), 32'd2);
                if (check_gap && have_prev)
                    check("frame_gap", 32'(cyc - prev_start), 32'(FRAME + 3));
                prev_start = cyc;
                have_prev  = 1;
            end

            if (rx_active) begin
                if (rx_k == 2) check("start_bit", 32'(tx), 32'd0);
                for (int j = 0; j < 8; j++)
                    if (rx_k == int'(CPB) * (j + 1) + 2) rx_byte[j] = tx;
`ifdef IIITB_UART_PARITY_EN
                if (rx_k == int'(CPB) * 9 + 2)
                    check("parity_bit", 32'(tx), 32'(^rx_byte));
`endif
                if (rx_k == int'(CPB) * (int'(NBITS) - 1) + 2) begin
                    check("stop_bit", 32'(tx), 32'd1);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_frame: got 0x%0h, expected none", rx_byte);
                    end else begin
                        check("frame_data", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                    rx_frames++;
                end
                if (rx_k == int'(FRAME) - 1) begin
                    check("tx_done_last_stop_cycle", 32'(tx_done), 32'd1);
                    rx_active = 0;
                end else if (tx_done) begin
                    check("tx_done_stray", 32'(tx_done), 32'd0);
                end
            end else if (tx_done) begin
                check("tx_done_stray", 32'(tx_done), 32'd0);
            end
            if (tx_done) done_cnt++;
        end
    end

    task automatic push(input logic [7:0] b, input bit expect_tx);
        @(negedge clk);
        wr_en  = 1'b1;
        buf_in = b;
        if (expect_tx) exp_q.push_back(b);
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int t = 0;
        while (rx_frames < target && t < budget) begin
            @(negedge clk);
            t++;
        end
        check("frame_wait_timeout", 32'(rx_frames >= target), 32'd1);
        repeat (CPB + 2) @(negedge clk);
    endtask

    initial begin
        int r0, d0, base, bad, t;
        logic [7:0] burst [8];
        int exp_fs;
        burst = '{8'd1, 8'd2, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(rd_en), 32'd0);
        check("rst_tx_done", 32'(tx_done), 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Single byte 0xA5
        tx_en = 1'b1;
        r0 = rd_pulses;
        d0 = done_cnt;
        push(8'hA5, 1);
        wait_frames(1, 4 * int'(FRAME));
        exp_fs = 1;
        check("single_frames_sent", 32'(frames_sent), 32'(exp_fs));
        check("single_rd_pulses", 32'(rd_pulses - r0), 32'd1);
        check("single_tx_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("single_buf_empty", 32'(buf_empty), 32'd1);
        check("single_busy_idle", 32'(busy), 32'd0);
`ifdef IIITB_UART_PARITY_EN
        push(8'h01, 1);
        wait_frames(2, 4 * int'(FRAME));
        exp_fs++;
        check("parity01_frames_sent", 32'(frames_sent), 32'(exp_fs));
`endif

        // Burst of 8 bytes, frames must be back-to-back
        check_gap = 1;
        have_prev = 0;
        base = rx_frames;
        r0 = rd_pulses;
        for (int i = 0; i < 8; i++) push(burst[i], 1);
        wait_frames(base + 8, 8 * (int'(FRAME) + 3) + 100);
        check_gap = 0;
        exp_fs += 8;
        check("burst_frames_sent", 32'(frames_sent), 32'(exp_fs));
        check("burst_rd_pulses", 32'(rd_pulses - r0), 32'd8);
        check("burst_buf_empty", 32'(buf_empty), 32'd1);

        // tx_en gating
        tx_en = 1'b0;
        push(8'h11, 1);
        push(8'h22, 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || rd_en !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("gate_hold_bad_cycles", 32'(bad), 32'd0);
        base = rx_frames;
        tx_en = 1'b1;
        t = 0;
        while (!(rx_active && rx_k >= int'(CPB) + 1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("gate_reach_data_timeout", 32'(t < 200), 32'd1);
        tx_en = 1'b0;
        wait_frames(base + 1, 4 * int'(FRAME));
        repeat (60) @(negedge clk);
        exp_fs++;
        check("gate_frames_sent", 32'(frames_sent), 32'(exp_fs));
        check("gate_busy_after", 32'(busy), 32'd0);
        check("gate_byte_held", 32'(buf_empty), 32'd0);
        check("gate_rx_frames", 32'(rx_frames), 32'(base + 1));
        exp_q.push_back(8'h22);
        tx_en = 1'b1;
        wait_frames(base + 2, 4 * int'(FRAME));
        exp_fs++;
        check("gate_second_frames_sent", 32'(frames_sent), 32'(exp_fs));

        // Reset during data bit 3
        push(8'h96, 0);
        t = 0;
        while (!(rx_active && rx_k == 4 * int'(CPB) + 1) && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("rst_reach_bit3_timeout", 32'(t < 200), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_frames_sent", 32'(frames_sent), 32'd0);
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        base = rx_frames;
        push(8'h3C, 1);
        wait_frames(base + 1, 4 * int'(FRAME));
        check("after_rst_frames_sent", 32'(frames_sent), 32'd1);
        check("after_rst_tx_done_cnt", 32'(done_cnt - d0), 32'd1);

        // frames_sent wrap
        @(negedge clk);
        force dut.frames_sent = 16'hFFFF;
        @(negedge clk);
        release dut.frames_sent;
        @(negedge clk);
        check("wrap_preload", 32'(frames_sent), 32'h0000_FFFF);
        base = rx_frames;
        push(8'h5A, 1);
        wait_frames(base + 1, 4 * int'(FRAME));
        check("wrap_frames_sent", 32'(frames_sent), 32'd0);

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
